load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between a valid/ready request port and a word-wide data memory. It handles
// B/H/W/BU/HU loads and stores. Define LSU_MISALIGNED_EN to allow accesses that cross a word boundary.
module load_store_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ACC0 = 3'd1;
    localparam logic [2:0] ACC1 = 3'd2;
    localparam logic [2:0] WR0  = 3'd3;
    localparam logic [2:0] WR1  = 3'd4;
    localparam logic [2:0] RESP = 3'd5;
    localparam int NB   = DATA_WIDTH / 8;
    localparam int BE_W = 2 * NB;

    logic [2:0]               state_q, state_d;
    logic                     we_q, we_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [ADDRESS_WIDTH+1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    buf0_q, buf0_d, buf1_q, buf1_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    logic span, req_align_err, req_err;
`ifdef LSU_MISALIGNED_EN
    assign span          = ({1'b0, addr_q[1:0]} + size_bytes(funct3_q[1:0])) > 3'd4;
    // A crossing access at the top word would need index+1, which does not exist.
    assign req_align_err = (({1'b0, req_addr[1:0]} + size_bytes(req_funct3[1:0])) > 3'd4)
                           && (req_addr[ADDRESS_WIDTH+1:2] == '1);
`else
    assign span          = 1'b0;
    assign req_align_err = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                           || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif

    assign req_err = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111)
                     || (req_we && req_funct3[2])
                     || ((req_addr >> (ADDRESS_WIDTH + 2)) != '0)
                     || req_align_err;

    // Two-word window: the low word comes from word index, the high word from index+1.
    logic [DATA_WIDTH-1:0]   win_lo, win_hi, load_data;
    logic [2*DATA_WIDTH-1:0] shifted, data_sh, bit_mask, merged;
    logic [BE_W-1:0]         size_mask, byte_en;
    logic [4:0]              shamt;

    always_comb begin
        shamt   = {addr_q[1:0], 3'b000};
        win_lo  = (state_q == ACC0) ? mem_rd : buf0_q;
        win_hi  = (state_q == ACC1) ? mem_rd : buf1_q;
        shifted = {win_hi, win_lo} >> shamt;
        case (funct3_q[1:0])
            2'b00:   load_data = {{(DATA_WIDTH-8){shifted[7] & ~funct3_q[2]}}, shifted[7:0]};
            2'b01:   load_data = {{(DATA_WIDTH-16){shifted[15] & ~funct3_q[2]}}, shifted[15:0]};
            default: load_data = shifted[DATA_WIDTH-1:0];
        endcase
        case (funct3_q[1:0])
            2'b00:   size_mask = BE_W'(1);
            2'b01:   size_mask = BE_W'(3);
            default: size_mask = BE_W'({NB{1'b1}});
        endcase
        byte_en = size_mask << addr_q[1:0];
        for (int i = 0; i < BE_W; i++) begin
            bit_mask[i*8 +: 8] = {8{byte_en[i]}};
        end
        data_sh = {{DATA_WIDTH{1'b0}}, wdata_q} << shamt;
        merged  = ({buf1_q, buf0_q} & ~bit_mask) | (data_sh & bit_mask);
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr[ADDRESS_WIDTH+1:0];
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (req_we && (req_funct3 == 3'b010) && (req_addr[1:0] == 2'b00)) begin
                        state_d = WR0;
                    end else begin
                        state_d = ACC0;
                    end
                end
            end
            ACC0: begin
                buf0_d = mem_rd;
                if (span) begin
                    state_d = ACC1;
                end else if (we_q) begin
                    state_d = WR0;
                end else begin
                    state_d = RESP;
                    rdata_d = load_data;
                    err_d   = 1'b0;
                end
            end
            ACC1: begin
                buf1_d = mem_rd;
                if (we_q) begin
                    state_d = WR0;
                end else begin
                    state_d = RESP;
                    rdata_d = load_data;
                    err_d   = 1'b0;
                end
            end
            WR0, WR1: begin
                if ((state_q == WR0) && span) begin
                    state_d = WR1;
                end else begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf0_q   <= '0;
            buf1_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    logic [ADDRESS_WIDTH-1:0] word_idx;
    logic                     mem_active;

    assign word_idx   = ((state_q == ACC1) || (state_q == WR1)) ? addr_q[ADDRESS_WIDTH+1:2] + 1'b1
                                                                : addr_q[ADDRESS_WIDTH+1:2];
    assign mem_active = (state_q == ACC0) || (state_q == ACC1) || (state_q == WR0) || (state_q == WR1);
    assign mem_a      = mem_active ? {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, word_idx} : '0;
    assign mem_we     = (state_q == WR0) || (state_q == WR1);
    assign mem_wd     = (state_q == WR1) ? merged[2*DATA_WIDTH-1:DATA_WIDTH] : merged[DATA_WIDTH-1:0];
    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit. It runs directed and random requests against a byte-level reference model
// and a reference memory. Expectations follow LSU_MISALIGNED_EN when that macro is defined.
module tb_load_store_unit;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = '0;
    logic [DW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [DW-1:0] mem_a;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    logic [31:0] mem     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] obs_rdata, exp_rdata;
    logic        obs_err, exp_err;
    int          obs_lat, exp_lat, obs_wes, exp_wes;
    logic [31:0] obs_resp_a;
    logic        obs_resp_we;

    load_store_unit #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[AW-1:0]];
    always @(posedge clk) if (mem_we) mem[mem_a[AW-1:0]] <= mem_wd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory, one call per request.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int   nbytes, off, word, a;
        logic bad, span, misal;
        logic [31:0] val;
        nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off    = int'(addr % 4);
        word   = int'(addr / 4);
        span   = (off + nbytes) > 4;
        misal  = (addr % nbytes) != 0;
        bad    = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) || (addr >= 4 * WORDS);
`ifdef LSU_MISALIGNED_EN
        bad = bad || (span && (word == WORDS - 1));
`else
        bad = bad || misal;
`endif
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        exp_wes   = 0;
        if (bad) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else if (we) begin
            for (int i = 0; i < nbytes; i++) begin
                a = int'(addr) + i;
                ref_mem[a / 4][8 * (a % 4) +: 8] = wdata[8 * i +: 8];
            end
            exp_lat = (nbytes == 4 && off == 0) ? 2 : (span ? 5 : 3);
            exp_wes = span ? 2 : 1;
        end else begin
            val = 32'd0;
            for (int i = 0; i < nbytes; i++) begin
                a = int'(addr) + i;
                val[8 * i +: 8] = ref_mem[a / 4][8 * (a % 4) +: 8];
            end
            if (!f3[2] && nbytes < 4 && val[8 * nbytes - 1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
            exp_rdata = val;
            exp_lat   = span ? 3 : 2;
        end
    endtask

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        obs_lat   = 1;
        obs_wes   = 0;
        while (!resp_valid && obs_lat < 12) begin
            if (mem_we) obs_wes++;
            @(posedge clk);
            #1;
            obs_lat++;
        end
        obs_rdata   = resp_rdata;
        obs_err     = resp_err;
        obs_resp_a  = mem_a;
        obs_resp_we = mem_we;
    endtask

    task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int w;
        run_txn(we, f3, addr, wdata);
        model(we, f3, addr, wdata);
        w = int'(addr[AW+1:2]);
        check({tag, "_rdata"}, obs_rdata, exp_rdata);
        check({tag, "_err"}, obs_err, exp_err);
        check({tag, "_lat"}, obs_lat, exp_lat);
        check({tag, "_we_pulses"}, obs_wes, exp_wes);
        check({tag, "_resp_mem_a"}, obs_resp_a, 32'd0);
        check({tag, "_resp_mem_we"}, obs_resp_we, 1'b0);
        check({tag, "_mem_word"}, mem[w], ref_mem[w]);
        check({tag, "_mem_word1"}, mem[(w + 1) % WORDS], ref_mem[(w + 1) % WORDS]);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr, rst_addr, mem4_before;
        logic        we;
        int          g, bad_words, sel;
        logic [2:0]  valid_f3 [5];
        valid_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        mem[5] = 32'h01234567; ref_mem[5] = 32'h01234567;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_req_ready", req_ready, 1'b1);
        check("idle_mem_a", mem_a, 32'd0);

        // Directed cases with constants taken from the worked examples.
        do_txn("lw_10", 1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_10_const", obs_rdata, 32'hDEADBEEF);
        check("lw_10_lat_const", obs_lat, 2);
        do_txn("lb_13", 1'b0, 3'b000, 32'h13, 32'h0);
        check("lb_13_const", obs_rdata, 32'hFFFFFFDE);
        repeat (2) @(posedge clk);
        #1;
        check("hold_rdata", resp_rdata, 32'hFFFFFFDE);
        check("hold_valid", resp_valid, 1'b0);
        do_txn("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0);
        check("lbu_13_const", obs_rdata, 32'h000000DE);
        do_txn("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0);
        check("lhu_10_const", obs_rdata, 32'h0000BEEF);
        do_txn("lh_12", 1'b0, 3'b001, 32'h12, 32'h0);
        check("lh_12_const", obs_rdata, 32'hFFFFDEAD);
        do_txn("sb_11", 1'b1, 3'b000, 32'h11, 32'h123456AA);
        check("sb_11_mem4", mem[4], 32'hDEADAAEF);
        check("sb_11_lat_const", obs_lat, 3);
        check("sb_11_pulses_const", obs_wes, 1);
        do_txn("lw_12", 1'b0, 3'b010, 32'h12, 32'h0);
`ifdef LSU_MISALIGNED_EN
        check("lw_12_const", obs_rdata, 32'h4567DEAD);
        check("lw_12_lat_const", obs_lat, 3);
`else
        check("lw_12_err_const", obs_err, 1'b1);
        check("lw_12_lat_const", obs_lat, 1);
`endif
        mem4_before = mem[4];
        do_txn("f3_011", 1'b0, 3'b011, 32'h10, 32'h0);
        check("f3_011_err_const", obs_err, 1'b1);
        do_txn("oob_1000", 1'b1, 3'b010, 32'h1000, 32'h55555555);
        check("oob_err_const", obs_err, 1'b1);
        check("oob_mem4_same", mem[4], mem4_before);
        do_txn("sbu_err", 1'b1, 3'b100, 32'h20, 32'h77);
        do_txn("sh_last", 1'b1, 3'b001, 32'hFFF, 32'hABCD);
        do_txn("lw_last", 1'b0, 3'b010, 32'hFFC, 32'h0);
        do_txn("sw_20", 1'b1, 3'b010, 32'h20, 32'hA5A5_5A5A);
        do_txn("sh_22", 1'b1, 3'b001, 32'h22, 32'h1234_BEEF);
        do_txn("sw_31", 1'b1, 3'b010, 32'h31, 32'h8765_4321);
        do_txn("lh_33", 1'b0, 3'b001, 32'h33, 32'h0);

        // Random requests, biased toward legal width codes and in-range addresses.
        for (int n = 0; n < 200; n++) begin
            sel  = $urandom_range(0, 15);
            addr = (sel == 0) ? $urandom : (sel == 1) ? 32'(4 * WORDS - $urandom_range(1, 4))
                                                       : 32'($urandom_range(0, 4 * WORDS - 1));
            f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                               : valid_f3[$urandom_range(0, 4)];
            we   = 1'($urandom_range(0, 1));
            do_txn("rand", we, f3, addr, $urandom);
        end

        // Reset while the first write of a store is on the memory port.
`ifdef LSU_MISALIGNED_EN
        rst_addr = 32'h42;
`else
        rst_addr = 32'h40;
`endif
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = rst_addr; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        g = 0;
        while (!mem_we && g < 10) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("rst_wr0_seen", mem_we, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ((rst_addr + i) / 4 == rst_addr / 4)
                ref_mem[(rst_addr + i) / 4][8 * ((rst_addr + i) % 4) +: 8] = req_wdata[8 * i +: 8];
        end
        @(posedge clk);
        #1;
        check("midrst_mem_we", mem_we, 1'b0);
        check("midrst_resp_valid", resp_valid, 1'b0);
        check("midrst_resp_rdata", resp_rdata, 32'd0);
        check("midrst_resp_err", resp_err, 1'b0);
        check("midrst_req_ready", req_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_req_ready", req_ready, 1'b1);
        g = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (resp_valid || mem_we) g++;
        end
        check("postrst_quiet", g, 0);
        check("postrst_word0", mem[rst_addr / 4], ref_mem[rst_addr / 4]);
        check("postrst_word1", mem[rst_addr / 4 + 1], ref_mem[rst_addr / 4 + 1]);
        do_txn("after_rst_lw", 1'b0, 3'b010, rst_addr & 32'hFFFF_FFFC, 32'h0);

        bad_words = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        check("final_mem_words_differing", bad_words, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
